climate_sched: RTL

- Shares one climate classifier between NUM_STATIONS weather-station requesters.
- Arbitrates station requests round-robin and latches the winning sample.
- Issues a start/done transaction to the classifier, applying a timeout.
- Returns the tagged condition to a single downstream consumer over valid/ready.
- Sits between the station front-ends and the classifier datapath.

---
 rtl/climate_pkg.sv | 22 ++
 rtl/climate_rr_arbiter.sv | 32 +++
 rtl/climate_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/climate_pkg.sv
// Shared types and widths for the climate classifier scheduler.
package climate_pkg;

    localparam int unsigned TEMP_W  = 8;
    localparam int unsigned PRESS_W = 11;

    typedef enum logic [2:0] {
        UNDEFINED = 3'd0,
        SNOW      = 3'd1,
        SUNNY     = 3'd2,
        STORM     = 3'd3,
        ERROR     = 3'd4
    } climate_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/climate_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i wins.
module climate_rr_arbiter #(
    parameter int unsigned NUM_STATIONS = 4,
    parameter int unsigned ID_W         = $clog2(NUM_STATIONS)
) (
    input  logic [NUM_STATIONS-1:0] req_i,
    input  logic [ID_W-1:0]         rr_ptr_i,
    output logic [NUM_STATIONS-1:0] grant_o,
    output logic [ID_W-1:0]         winner_o,
    output logic                    any_req_o
);

    logic [ID_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        grant_o   = '0;
        winner_o  = '0;
        idx       = '0;
        any_req_o = |req_i;
        for (int k = int'(NUM_STATIONS) - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_i) + k) % int'(NUM_STATIONS));
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
        if (any_req_o) begin
            grant_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/climate_sched.sv
// Shares one climate classifier between several stations: arbitrate, issue, wait, respond.
module climate_sched
    import climate_pkg::*;
#(
    parameter int unsigned NUM_STATIONS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned ID_W           = $clog2(NUM_STATIONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_STATIONS-1:0]         req_valid,
    input  logic [TEMP_W*NUM_STATIONS-1:0]  req_temperature,
    input  logic [PRESS_W*NUM_STATIONS-1:0] req_pressure,
    output logic [NUM_STATIONS-1:0]         req_ready,
    output logic                            cls_start,
    output logic [TEMP_W-1:0]               cls_temperature,
    output logic [PRESS_W-1:0]              cls_pressure,
    input  logic                            cls_done,
    input  logic [2:0]                      cls_condition,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [ID_W-1:0]                 res_id,
    output logic [2:0]                      res_condition,
    output logic                            res_timeout,
    output logic [7:0]                      err_count
);

    // Last WAIT cycle index; timer counts WAIT cycles already spent without cls_done.
    localparam logic [7:0] TimerLast = 8'(TIMEOUT_CYCLES - 1);

    sched_state_t         state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [7:0]           timer_q;
    logic                 cls_start_q;
    logic [TEMP_W-1:0]    cls_temp_q;
    logic [PRESS_W-1:0]   cls_press_q;
    logic                 res_valid_q;
    logic [ID_W-1:0]      res_id_q;
    logic [2:0]           res_cond_q;
    logic                 res_timeout_q;
    logic [7:0]           err_q;

    logic [NUM_STATIONS-1:0] grant;
    logic [ID_W-1:0]         winner;
    logic                    any_req;
    logic [ID_W-1:0]         rr_next;
    logic [TEMP_W-1:0]       temp_sel;
    logic [PRESS_W-1:0]      press_sel;

    climate_rr_arbiter #(
        .NUM_STATIONS (NUM_STATIONS),
        .ID_W         (ID_W)
    ) u_arbiter (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (grant),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Select the winning station's sample and the pointer just past it.
    always_comb begin
        temp_sel  = '0;
        press_sel = '0;
        for (int i = 0; i < int'(NUM_STATIONS); i++) begin
            if (winner == ID_W'(i)) begin
                temp_sel  = req_temperature[i*TEMP_W +: TEMP_W];
                press_sel = req_pressure[i*PRESS_W +: PRESS_W];
            end
        end
        rr_next = (winner == ID_W'(NUM_STATIONS - 1)) ? '0 : winner + 1'b1;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            cls_start_q   <= 1'b0;
            cls_temp_q    <= '0;
            cls_press_q   <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_cond_q    <= UNDEFINED;
            res_timeout_q <= 1'b0;
            err_q         <= '0;
        end else begin
            cls_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        cls_temp_q  <= temp_sel;
                        cls_press_q <= press_sel;
                        res_id_q    <= winner;
                        rr_ptr_q    <= rr_next;
                        cls_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A completion on the final WAIT cycle beats the timeout.
                    if (cls_done) begin
                        res_cond_q    <= cls_condition;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                        if (cls_condition == ERROR && err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                    end else if (timer_q == TimerLast) begin
                        res_cond_q    <= ERROR;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                        if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE) ? grant : '0;
    assign cls_start       = cls_start_q;
    assign cls_temperature = cls_temp_q;
    assign cls_pressure    = cls_press_q;
    assign res_valid       = res_valid_q;
    assign res_id          = res_id_q;
    assign res_condition   = res_cond_q;
    assign res_timeout     = res_timeout_q;
    assign err_count       = err_q;

endmodule
